// File: rtl/rr_arb_if.sv
// Request/grant bundle between requesting agents and the round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter.
interface rr_arb_if #(
   parameter int N   = 8,
   parameter int IDW = 3
);
   logic [N-1:0]   req;
   logic           done;
   logic [N-1:0]   grant;
   logic [IDW-1:0] grant_id;
   logic           grant_vld;
   logic           timeout;

   modport master (
      output req, done,
      input  grant, grant_id, grant_vld, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_id, grant_vld, timeout
   );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a one-hot grant decoded from the winner index.
// A grant is held until done, the owner drops its request, or MAX_HOLD expires.
//
// state | meaning
// IDLE  | no owner; the first request at or after ptr wins
// GRANT | owner holds the resource; hold_cnt counts cycles held
// GAP   | mandatory turnaround cycle; requests are ignored
module rr_onehot_arbiter #(
   parameter int N        = 8,
   parameter int IDW      = 3,
   parameter int MAX_HOLD = 16
) (
   input logic     clk,
   input logic     rst,
   rr_arb_if.slave bus
);
   localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [N-1:0]   grant_q, grant_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;
   logic           grant_vld_q, grant_vld_d;
   logic           timeout_q, timeout_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

   logic           win_found;
   logic [IDW-1:0] win_id;
   logic [IDW-1:0] cand;
   logic           rel_done, rel_drop, rel_to;

   // Search order ptr, ptr+1, ... relies on N being a power of two so the
   // IDW-bit addition wraps modulo N.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         cand = ptr_q + IDW'(i);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign rel_done = bus.done;
   assign rel_drop = !bus.req[grant_id_q];
   assign rel_to   = (hold_cnt_q == HOLD_LAST);

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      grant_id_d  = grant_id_q;
      grant_vld_d = grant_vld_q;
      timeout_d   = 1'b0;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d     = ST_GRANT;
               grant_d     = N'(1) << win_id;
               grant_id_d  = win_id;
               grant_vld_d = 1'b1;
               hold_cnt_d  = '0;
            end
         end
         ST_GRANT: begin
            if (rel_done || rel_drop || rel_to) begin
               state_d     = ST_GAP;
               grant_d     = '0;
               grant_vld_d = 1'b0;
               ptr_d       = grant_id_q + IDW'(1);
               hold_cnt_d  = '0;
               // Timeout is reported only when the hold limit alone forced release.
               timeout_d   = rel_to && !rel_done && !rel_drop;
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         grant_id_q  <= '0;
         grant_vld_q <= 1'b0;
         timeout_q   <= 1'b0;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         grant_id_q  <= grant_id_d;
         grant_vld_q <= grant_vld_d;
         timeout_q   <= timeout_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.grant_vld = grant_vld_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scenario bench for rr_onehot_arbiter: expected owners are queued as requests
// are driven and popped when a grant appears.
module tb_rr_onehot_arbiter;
   localparam int N        = 8;
   localparam int IDW      = 3;
   localparam int MAX_HOLD = 16;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   exp_q[$];

   rr_arb_if #(.N(N), .IDW(IDW)) bus ();

   rr_onehot_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Invariant: grant is zero or one-hot and matches grant_vld << grant_id.
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (!$onehot0(bus.grant) ||
             bus.grant !== (bus.grant_vld ? (8'(1) << bus.grant_id) : 8'h00)) begin
            bad++;
            $display("FAIL grant_shape: grant=%h vld=%b id=%0d", bus.grant, bus.grant_vld, bus.grant_id);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.req  = '0;
      bus.done = 1'b0;
      rst      = 1'b1;
      exp_q.delete();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic wait_grant(input int budget, output bit got, output int waited);
      got    = 1'b0;
      waited = 0;
      while (!bus.grant_vld && waited < budget) begin
         step();
         waited++;
      end
      got = bus.grant_vld;
   endtask

   function automatic int pop_exp();
      if (exp_q.size() == 0) return -1;
      return exp_q.pop_front();
   endfunction

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         total++;
         if (bus.grant !== 8'h00 || bus.grant_vld !== 1'b0 || bus.timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle cyc%0d: grant=%h vld=%b to=%b want 00/0/0", i, bus.grant, bus.grant_vld, bus.timeout);
         end
         step();
      end
   endtask

   task automatic test_priority();
      int e;
      do_reset();
      bus.req = 8'h24;
      exp_q.push_back(2);
      exp_q.push_back(5);
      step();
      e = pop_exp();
      total++;
      if (e < 0 || bus.grant_vld !== 1'b1 || bus.grant_id !== 3'(e) || bus.grant !== 8'(1 << e)) begin
         bad++;
         $display("FAIL prio_first: grant=%h id=%0d vld=%b want id=%0d", bus.grant, bus.grant_id, bus.grant_vld, e);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      total++;
      if (bus.grant !== 8'h00 || bus.timeout !== 1'b0) begin
         bad++;
         $display("FAIL prio_gap: grant=%h to=%b want 00/0", bus.grant, bus.timeout);
      end
      step();
      total++;
      if (bus.grant !== 8'h00) begin
         bad++;
         $display("FAIL prio_idle: grant=%h want 00", bus.grant);
      end
      step();
      e = pop_exp();
      total++;
      if (e < 0 || bus.grant_vld !== 1'b1 || bus.grant_id !== 3'(e) || bus.grant !== 8'(1 << e)) begin
         bad++;
         $display("FAIL prio_second: grant=%h id=%0d want id=%0d", bus.grant, bus.grant_id, e);
      end
      bus.req = 8'h00;
   endtask

   task automatic test_rotation();
      bit got;
      int waited, e;
      do_reset();
      bus.req = 8'hFF;
      for (int k = 0; k <= N; k++) exp_q.push_back(k % N);
      for (int k = 0; k <= N; k++) begin
         wait_grant(8, got, waited);
         e = pop_exp();
         total++;
         if (!got || e < 0 || bus.grant_id !== 3'(e) || bus.grant !== 8'(1 << e)) begin
            bad++;
            $display("FAIL rotate_%0d: got=%b grant=%h id=%0d want id=%0d", k, got, bus.grant, bus.grant_id, e);
         end
         if (k > 0) begin
            total++;
            if (waited !== 2) begin
               bad++;
               $display("FAIL rotate_gap_%0d: idle cycles=%0d want 2", k, waited);
            end
         end
         bus.done = 1'b1;
         step();
         bus.done = 1'b0;
      end
      bus.req = 8'h00;
   endtask

   task automatic test_timeout();
      int held, e;
      do_reset();
      bus.req = 8'h01;
      exp_q.push_back(0);
      exp_q.push_back(0);
      step();
      e = pop_exp();
      total++;
      if (e < 0 || bus.grant !== 8'(1 << e) || bus.grant_id !== 3'(e)) begin
         bad++;
         $display("FAIL to_grant: grant=%h want %0d", bus.grant, e);
      end
      held = 0;
      while (bus.grant_vld && held < 40) begin
         held++;
         step();
      end
      total++;
      if (held !== MAX_HOLD) begin
         bad++;
         $display("FAIL to_hold_len: held=%0d want %0d", held, MAX_HOLD);
      end
      total++;
      if (bus.timeout !== 1'b1 || bus.grant !== 8'h00) begin
         bad++;
         $display("FAIL to_pulse: to=%b grant=%h want 1/00", bus.timeout, bus.grant);
      end
      step();
      total++;
      if (bus.timeout !== 1'b0 || bus.grant !== 8'h00) begin
         bad++;
         $display("FAIL to_pulse_end: to=%b grant=%h want 0/00", bus.timeout, bus.grant);
      end
      step();
      e = pop_exp();
      total++;
      if (e < 0 || bus.grant !== 8'(1 << e) || bus.grant_id !== 3'(e)) begin
         bad++;
         $display("FAIL to_regrant: grant=%h want id %0d", bus.grant, e);
      end
      bus.req = 8'h00;
   endtask

   task automatic test_release_causes();
      bit got;
      int waited, e;
      do_reset();
      bus.req = 8'h01;
      exp_q.push_back(0);
      exp_q.push_back(0);
      step();
      e = pop_exp();
      total++;
      if (e < 0 || bus.grant !== 8'(1 << e)) begin
         bad++;
         $display("FAIL coin_grant: grant=%h want id %0d", bus.grant, e);
      end
      repeat (MAX_HOLD - 1) step();
      total++;
      if (bus.grant_vld !== 1'b1) begin
         bad++;
         $display("FAIL coin_still_held: vld=%b want 1", bus.grant_vld);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      total++;
      if (bus.grant_vld !== 1'b0 || bus.timeout !== 1'b0) begin
         bad++;
         $display("FAIL coin_release: vld=%b to=%b want 0/0", bus.grant_vld, bus.timeout);
      end
      wait_grant(8, got, waited);
      e = pop_exp();
      total++;
      if (!got || e < 0 || bus.grant !== 8'(1 << e)) begin
         bad++;
         $display("FAIL drop_grant: got=%b grant=%h want id %0d", got, bus.grant, e);
      end
      repeat (3) step();
      total++;
      if (bus.grant_vld !== 1'b1) begin
         bad++;
         $display("FAIL drop_held: vld=%b want 1", bus.grant_vld);
      end
      bus.req = 8'h00;
      step();
      total++;
      if (bus.grant_vld !== 1'b0 || bus.timeout !== 1'b0) begin
         bad++;
         $display("FAIL drop_release: vld=%b to=%b want 0/0", bus.grant_vld, bus.timeout);
      end
   endtask

   task automatic test_async_reset();
      bit got;
      int waited, e;
      do_reset();
      bus.req = 8'h08;
      exp_q.push_back(3);
      exp_q.push_back(3);
      step();
      e = pop_exp();
      total++;
      if (e < 0 || bus.grant !== 8'(1 << e)) begin
         bad++;
         $display("FAIL ar_first: grant=%h want id %0d", bus.grant, e);
      end
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      wait_grant(8, got, waited);
      e = pop_exp();
      total++;
      if (!got || e < 0 || bus.grant !== 8'(1 << e)) begin
         bad++;
         $display("FAIL ar_second: got=%b grant=%h want id %0d", got, bus.grant, e);
      end
      step();
      rst = 1'b1;
      #1;
      total++;
      if (bus.grant !== 8'h00 || bus.grant_vld !== 1'b0 || bus.timeout !== 1'b0) begin
         bad++;
         $display("FAIL ar_async: grant=%h vld=%b to=%b want 00/0/0", bus.grant, bus.grant_vld, bus.timeout);
      end
      bus.req = 8'h88;
      exp_q.push_back(3);
      step();
      rst = 1'b0;
      wait_grant(4, got, waited);
      e = pop_exp();
      total++;
      if (!got || e < 0 || bus.grant !== 8'(1 << e) || bus.grant_id !== 3'(e)) begin
         bad++;
         $display("FAIL ar_ptr_reset: got=%b grant=%h id=%0d want id %0d", got, bus.grant, bus.grant_id, e);
      end
      bus.req = 8'h00;
   endtask

   initial begin
      rst      = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;
      #1;
      test_reset();
      test_priority();
      test_rotation();
      test_timeout();
      test_release_causes();
      test_async_reset();
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
